// File: rtl/par2serial_idle.sv
// Purpose: MSB-first serializer; every WIDTH-cycle slot carries a data word or the IDLE comma.
// Latency: MSB of a word accepted at a load edge is on serial_out right after that edge.
// Backpressure: ready is high only in the load cycle; no buffering, so the producer holds data until it is accepted.
module par2serial_idle #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] IDLE  = WIDTH'(8'hBC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             serial_out,
  output logic             frame_start,
  output logic             idle_out
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             load;

  // A slot boundary is whenever the bit counter is back at zero; reset blocks acceptance.
  assign load       = (bit_cnt == '0) && !reset;
  assign ready      = load;
  assign serial_out = shreg[WIDTH-1];

  // Bit counter, shift register and frame flags; IDLE is substituted when nothing valid is offered at a load slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_start <= 1'b0;
      idle_out    <= 1'b0;
    end else begin
      bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
      if (load) begin
        shreg       <= valid_in ? data_in : IDLE;
        idle_out    <= ~valid_in;
        frame_start <= 1'b1;
      end else begin
        shreg       <= {shreg[WIDTH-2:0], 1'b0};
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_par2serial_idle.sv
// Bench for par2serial_idle: per-cycle stimulus, scoreboard of expected serial bits/flags.
// Expected bits are queued at each load edge the bench predicts and popped one per clock.
// Whole received words are also compared against literal constants.
module tb_par2serial_idle;
  localparam int         WIDTH = 8;
  localparam logic [7:0] IDLE  = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready, serial_out, frame_start, idle_out;

  par2serial_idle #(.WIDTH(WIDTH), .IDLE(IDLE)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready(ready), .serial_out(serial_out), .frame_start(frame_start), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic fs; logic idl; } exp_t;
  exp_t        sb[$];
  int          cnt_m  = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rx     = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check ready, predict a load, then compare the post-edge outputs.
  task automatic tick(input logic r, input logic v, input logic [7:0] d);
    exp_t       e;
    logic [7:0] w;
    reset = r; valid_in = v; data_in = d;
    #1;
    check("ready", {31'b0, ready}, {31'b0, (!r && cnt_m == 0)});
    if (!r && cnt_m == 0) begin
      w = v ? d : IDLE;
      for (int i = 0; i < WIDTH; i++) begin
        e.b = w[WIDTH-1-i]; e.fs = (i == 0); e.idl = !v;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    rx = {rx[30:0], serial_out};
    if (r) begin
      sb.delete();
      cnt_m = 0;
      check("rst_serial", {31'b0, serial_out}, 32'd0);
      check("rst_fs", {31'b0, frame_start}, 32'd0);
      check("rst_idle", {31'b0, idle_out}, 32'd0);
    end else begin
      cnt_m = (cnt_m + 1) % WIDTH;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("serial", {31'b0, serial_out}, {31'b0, e.b});
        check("frame_start", {31'b0, frame_start}, {31'b0, e.fs});
        check("idle_out", {31'b0, idle_out}, {31'b0, e.idl});
      end
    end
  endtask

  // Present a word at a load edge, then let the rest of its frame shift out with valid low.
  task automatic send(input logic [7:0] d);
    tick(1'b0, 1'b1, d);
    for (int i = 1; i < WIDTH; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    // Reset for two cycles, then the first released edge loads A5.
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    send(8'hA5);
    check("word_a5", {24'b0, rx[7:0]}, 32'h0000_00A5);

    // Idle line: three consecutive comma frames.
    for (int i = 0; i < 3 * WIDTH; i++) tick(1'b0, 1'b0, 8'h00);
    check("idle_x3", {8'b0, rx[23:0]}, 32'h00BC_BCBC);

    // Back-to-back words, no gaps.
    send(8'hFF);
    send(8'h00);
    send(8'h3C);
    check("b2b_ff003c", {8'b0, rx[23:0]}, 32'h00FF_003C);

    // 55 raised at bit_cnt==3 and held: current (idle) frame unchanged, 55 loads next slot.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
    while (cnt_m != 0) tick(1'b0, 1'b1, 8'h55);
    check("late_valid_idle", {24'b0, rx[7:0]}, 32'h0000_00BC);
    send(8'h55);
    check("word_55", {24'b0, rx[7:0]}, 32'h0000_0055);

    // Reset at bit_cnt==4 during A5: frame abandoned, fresh load on first released edge.
    tick(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
    check("mid_rst_pos", cnt_m, 32'd4);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    send(8'hA5);
    check("word_a5_after_rst", {24'b0, rx[7:0]}, 32'h0000_00A5);

    // Valid pulsed only at bit_cnt==5 with 12: never transmitted, next frame is IDLE.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h12);
    while (cnt_m != 0) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < WIDTH; i++) tick(1'b0, 1'b0, 8'h00);
    check("pulse_ignored", {16'b0, rx[15:0]}, 32'h0000_BCBC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/par2serial_idle.md
Name: par2serial_idle

Overview:
- Downstream stage of the PHY 2:1 byte interleaving mux.
- Takes the mux's 8-bit word plus valid flag and serializes it MSB-first onto a 1-bit line, one bit per clk.
- Every WIDTH-cycle frame slot carries either an accepted data word or the IDLE comma character, so the receiver-side serial-to-parallel stage can always find word alignment.

Parameters:
WIDTH, 8, word width in bits; also the frame length in clk cycles (WIDTH >= 2)
IDLE, 8'hBC, comma/idle word sent when no valid data is presented at a load slot (WIDTH bits)

Ports:
clk  input  1  bit clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word from the upstream mux (its Salida_conductual)
valid_in  input  1  data_in qualifier (the mux's validsalida)
ready  output  1  combinational; high in the load cycle (bit_cnt==0 and reset==0)
serial_out  output  1  serial bit stream, MSB first; equals shreg[WIDTH-1] (flop output)
frame_start  output  1  registered; high while serial_out carries bit WIDTH-1 of a word
idle_out  output  1  registered; high for the entire frame in which the IDLE word is being shifted

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On a rising edge with reset==1:
  - bit_cnt=0, shreg=0, frame_start=0, idle_out=0.
  - Hence serial_out=0.
  - ready=0 while reset is high.
- bit_cnt: log2ceil(WIDTH)-bit counter, increments every cycle, wraps WIDTH-1 -> 0.
- Load cycle is the edge where bit_cnt==0:
  - shreg <= valid_in ? data_in : IDLE.
  - idle_out <= ~valid_in.
  - frame_start <= 1.
- Other cycles:
  - shreg <= {shreg[WIDTH-2:0], 1'b0}.
  - frame_start <= 0.
  - idle_out holds its value.
- Handshake:
  - A word is accepted iff ready && valid_in at the rising edge.
  - valid_in or data_in presented while ready==0 is ignored, and no state changes.
  - The producer holds data until accepted.
  - No backpressure beyond ready; no buffering.
- Latency: the MSB of the accepted word appears on serial_out right after the load edge. Bit k (MSB=WIDTH-1) is visible during cycle WIDTH-1-k of the frame. The LSB is visible in the cycle before the next load.
- Continuous stream: frames are back-to-back, with no gaps. With no valid data, the line carries IDLE repeatedly.
- First load after reset release: the first rising edge with reset==0 is a load edge, because bit_cnt is 0.
- Reset mid-frame:
  - The frame in progress is abandoned; its remaining bits are never sent.
  - The word is lost; the producer must re-present it.
  - serial_out=0 from the next edge.
- valid_in toggling within a frame has no effect. Only the value at the load edge matters.
- data_in is don't-care when valid_in==0 at the load edge.

Test Plan:
- reset 2 cycles; release with valid_in=1, data_in=8'hA5 -> ready=1 first cycle; serial_out over the next 8 cycles = 1,0,1,0,0,1,0,1; frame_start=1 only in the first of them; idle_out=0.
- release with valid_in=0 -> frame carries 8'hBC = 1,0,1,1,1,1,0,0; idle_out=1 for all 8 cycles; continuous BC frames while valid_in stays 0.
- back-to-back words 8'hFF, 8'h00, 8'h3C, each presented at its load edge -> 24 contiguous bits 11111111 00000000 00111100; frame_start pulses every 8 cycles exactly.
- valid_in=1 with data_in=8'h55 raised at bit_cnt==3 and held -> word ignored until the next load edge (ready high); current frame completes unchanged, then 0,1,0,1,0,1,0,1.
- reset asserted at bit_cnt==4 during 8'hA5 -> serial_out=0, frame_start=0, idle_out=0 from the next edge; after release a fresh load occurs on the first edge and bit_cnt restarts at 0.
- valid_in pulsed high only at bit_cnt==5 with 8'h12, low at the load edge -> next frame is IDLE 8'hBC, and 8'h12 is never transmitted.
